// File: rtl/wbdown_ffs.sv
// Lowest-set-bit priority encoder: index of the lowest set bit plus a
// valid flag when any bit is set.
module wbdown_ffs #(
    parameter int RATIO   = 16,
    parameter int LGRATIO = 4
) (
    input  logic [RATIO-1:0]   mask,
    output logic [LGRATIO-1:0] idx,
    output logic               vld
);

    always_comb begin
        idx = '0;
        vld = |mask;
        // Scan downward so the lowest set bit is the last (winning) write
        for (int i = RATIO - 1; i >= 0; i--) begin
            if (mask[i])
                idx = LGRATIO'(i);
        end
    end

endmodule

// File: rtl/wbdown_dma.sv
// Wishbone width down-converter: splits one wide request into a burst of
// narrow requests for the selected words and merges read data into one ack.
module wbdown_dma #(
    parameter int ADDRESS_WIDTH     = 30,
    parameter int BUS_WIDTH         = 512,
    parameter int NARROW_WIDTH      = 32,
    parameter bit OPT_LITTLE_ENDIAN = 1'b0,
    parameter bit OPT_LOWPOWER      = 1'b0,
    localparam int WAW = ADDRESS_WIDTH - $clog2(BUS_WIDTH / 8),
    localparam int NAW = ADDRESS_WIDTH - $clog2(NARROW_WIDTH / 8)
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_wcyc,
    input  logic                      i_wstb,
    input  logic                      i_wwe,
    input  logic [WAW-1:0]            i_waddr,
    input  logic [BUS_WIDTH-1:0]      i_wdata,
    input  logic [BUS_WIDTH/8-1:0]    i_wsel,
    output logic                      o_wstall,
    output logic                      o_wack,
    output logic                      o_werr,
    output logic [BUS_WIDTH-1:0]      o_wdata,
    output logic                      o_ncyc,
    output logic                      o_nstb,
    output logic                      o_nwe,
    output logic [NAW-1:0]            o_naddr,
    output logic [NARROW_WIDTH-1:0]   o_ndata,
    output logic [NARROW_WIDTH/8-1:0] o_nsel,
    input  logic                      i_nstall,
    input  logic                      i_nack,
    input  logic                      i_nerr,
    input  logic [NARROW_WIDTH-1:0]   i_ndata
);

    localparam int RATIO   = BUS_WIDTH / NARROW_WIDTH;
    localparam int LGRATIO = $clog2(RATIO);
    localparam int WSW     = BUS_WIDTH / 8;
    localparam int NSW     = NARROW_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t               state, state_n;
    logic [WAW-1:0]       addr_r, addr_n;
    logic                 we_r, we_n;
    logic [BUS_WIDTH-1:0] data_r, data_n;
    logic [WSW-1:0]       sel_r, sel_n;
    logic [RATIO-1:0]     issue_m, issue_n;
    logic [RATIO-1:0]     ack_m, ack_n;
    logic [BUS_WIDTH-1:0] rdata, rdata_n;
    logic                 ncyc_r, ncyc_n;
    logic                 nstb_r, nstb_n;
    logic                 wack_r, wack_n;
    logic                 werr_r, werr_n;
    logic [BUS_WIDTH-1:0] wdata_r, wdata_n;

    logic [RATIO-1:0]     wmask;
    logic [LGRATIO-1:0]   iss_idx, ack_idx;
    logic                 iss_vld, ack_vld;
    logic [LGRATIO-1:0]   iss_p, ack_p;

    // Logical word k lives in physical slice k (little) or RATIO-1-k (big)
    always_comb begin
        wmask = '0;
        for (int k = 0; k < RATIO; k++)
            wmask[k] = |i_wsel[(OPT_LITTLE_ENDIAN ? k : RATIO - 1 - k) * NSW +: NSW];
    end

    wbdown_ffs #(.RATIO(RATIO), .LGRATIO(LGRATIO)) u_ffs_issue (
        .mask (issue_m),
        .idx  (iss_idx),
        .vld  (iss_vld)
    );

    wbdown_ffs #(.RATIO(RATIO), .LGRATIO(LGRATIO)) u_ffs_ack (
        .mask (ack_m),
        .idx  (ack_idx),
        .vld  (ack_vld)
    );

    // RATIO is a power of two, so RATIO-1-k is simply ~k
    assign iss_p = OPT_LITTLE_ENDIAN ? iss_idx : ~iss_idx;
    assign ack_p = OPT_LITTLE_ENDIAN ? ack_idx : ~ack_idx;

    always_comb begin
        state_n = state;
        addr_n  = addr_r;
        we_n    = we_r;
        data_n  = data_r;
        sel_n   = sel_r;
        issue_n = issue_m;
        ack_n   = ack_m;
        rdata_n = rdata;
        ncyc_n  = ncyc_r;
        nstb_n  = nstb_r;
        wack_n  = 1'b0;
        werr_n  = 1'b0;
        wdata_n = OPT_LOWPOWER ? '0 : wdata_r;

        case (state)
            S_IDLE: begin
                if (i_wcyc && i_wstb) begin
                    addr_n = i_waddr;
                    we_n   = i_wwe;
                    data_n = i_wdata;
                    sel_n  = i_wsel;
                    if (wmask == '0) begin
                        wack_n  = 1'b1;
                        wdata_n = '0;
                    end else begin
                        issue_n = wmask;
                        ack_n   = wmask;
                        rdata_n = '0;
                        ncyc_n  = 1'b1;
                        nstb_n  = 1'b1;
                        state_n = S_ISSUE;
                    end
                end
            end

            default: begin
                if (!i_wcyc || i_nerr) begin
                    // Abort wins over error: a departed master wants no response
                    werr_n  = i_wcyc;
                    issue_n = '0;
                    ack_n   = '0;
                    ncyc_n  = 1'b0;
                    nstb_n  = 1'b0;
                    state_n = S_IDLE;
                end else begin
                    if (state == S_ISSUE && iss_vld && !i_nstall) begin
                        issue_n[iss_idx] = 1'b0;
                        if (issue_n == '0) begin
                            nstb_n  = 1'b0;
                            state_n = S_WAIT;
                        end
                    end
                    if (i_nack && ack_vld) begin
                        ack_n[ack_idx] = 1'b0;
                        if (!we_r)
                            rdata_n[int'(ack_p) * NARROW_WIDTH +: NARROW_WIDTH] = i_ndata;
                    end
                    if (ack_n == '0) begin
                        issue_n = '0;
                        ncyc_n  = 1'b0;
                        nstb_n  = 1'b0;
                        wack_n  = 1'b1;
                        wdata_n = we_r ? '0 : rdata_n;
                        state_n = S_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state   <= S_IDLE;
            addr_r  <= '0;
            we_r    <= 1'b0;
            data_r  <= '0;
            sel_r   <= '0;
            issue_m <= '0;
            ack_m   <= '0;
            rdata   <= '0;
            ncyc_r  <= 1'b0;
            nstb_r  <= 1'b0;
            wack_r  <= 1'b0;
            werr_r  <= 1'b0;
            wdata_r <= '0;
        end else begin
            state   <= state_n;
            addr_r  <= addr_n;
            we_r    <= we_n;
            data_r  <= data_n;
            sel_r   <= sel_n;
            issue_m <= issue_n;
            ack_m   <= ack_n;
            rdata   <= rdata_n;
            ncyc_r  <= ncyc_n;
            nstb_r  <= nstb_n;
            wack_r  <= wack_n;
            werr_r  <= werr_n;
            wdata_r <= wdata_n;
        end
    end

    assign o_wstall = (state != S_IDLE);
    assign o_wack   = wack_r;
    assign o_werr   = werr_r;
    assign o_wdata  = wdata_r;
    assign o_ncyc   = ncyc_r;
    assign o_nstb   = nstb_r;
    assign o_nwe    = we_r;

    // Narrow payload follows the lowest pending word of the issue mask
    assign o_naddr = (OPT_LOWPOWER && !nstb_r) ? '0 : {addr_r, iss_idx};
    assign o_ndata = (OPT_LOWPOWER && !nstb_r) ? '0
                   : data_r[int'(iss_p) * NARROW_WIDTH +: NARROW_WIDTH];
    assign o_nsel  = (OPT_LOWPOWER && !nstb_r) ? '0
                   : sel_r[int'(iss_p) * NSW +: NSW];

endmodule
